// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice stepped over WIDTH cycles, start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via a + ~b + 1).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s_bit, c_bit;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign {c_bit, s_bit} = full_add(a_sh_q[0], b_sh_q[0], carry_q);
  // Concatenate-then-drop keeps the MSB-side shift legal for WIDTH=1.
  assign s_ext = {s_bit, s_sh_q};

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        s_sh_d  = s_ext[WIDTH:1];
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = c_bit;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = s_ext[WIDTH:1];
          cout_d  = c_bit;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 vector table plus WIDTH=1 and handshake corner cases.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, sub8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, sub1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts);
    a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~ta; b8 = 8'h3C; cin8 = ~tc; sub8 = ~ts;
  endtask

  task automatic wait_done(input string nm, input logic [7:0] es, input logic ec, input bit repulse);
    int cyc = 0;
    int bc  = 0;
    while (!done8 && cyc < 20) begin
      if (busy8) bc++;
      @(negedge clk);
      cyc++;
      if (repulse && cyc == 3) begin a8 = 8'h55; b8 = 8'h55; start8 = 1'b1; end
      else if (repulse && cyc == 4) start8 = 1'b0;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'd8);
    chk({nm, "_busy_cycles"}, 64'(bc), 64'd8);
    chk({nm, "_done"}, 64'(done8), 64'd1);
    chk({nm, "_busy_low"}, 64'(busy8), 64'd0);
    chk({nm, "_sum"}, 64'(sum8), 64'(es));
    chk({nm, "_cout"}, 64'(cout8), 64'(ec));
  endtask

  initial begin
    logic [7:0] prev_sum;
    bit         saw_done;

    vecs.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
    vecs.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1});
    vecs.push_back('{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy8), 0);
    chk("rst_done", 64'(done8), 0);
    chk("rst_sum", 64'(sum8), 0);
    chk("rst_cout", 64'(cout8), 0);
    chk("rst_w1_outs", 64'({busy1, done1, sum1, cout1}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    prev_sum = 8'h00;
    for (int i = 0; i < vecs.size(); i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      chk($sformatf("v%0d_sum_hold", i), 64'(sum8), 64'(prev_sum));
      wait_done($sformatf("v%0d", i), vecs[i].s, vecs[i].co, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 64'(done8), 0);
      prev_sum = vecs[i].s;
    end

    // Start re-pulsed mid-RUN is ignored; next start issued in the DONE cycle.
    start_op(8'h0F, 8'h01, 1'b0, 1'b0);
    wait_done("repulse", 8'h10, 1'b0, 1'b1);
    start_op(8'h55, 8'h55, 1'b0, 1'b0);
    wait_done("b2b", 8'hAA, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_done_pulse", 64'(done8), 0);

    // Asynchronous reset during RUN cycle 4.
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy8), 0);
    chk("abort_done", 64'(done8), 0);
    chk("abort_sum", 64'(sum8), 0);
    chk("abort_cout", 64'(cout8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 0);
    start_op(8'h03, 8'h04, 1'b0, 1'b0);
    wait_done("post_abort", 8'h07, 1'b0, 1'b0);
    @(negedge clk);

    // WIDTH=1: one RUN cycle, back-to-back start in DONE.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    chk("w1a_busy", 64'(busy1), 1);
    chk("w1a_done_early", 64'(done1), 0);
    @(negedge clk);
    chk("w1a_done", 64'(done1), 1);
    chk("w1a_busy_low", 64'(busy1), 0);
    chk("w1a_sum", 64'(sum1), 1);
    chk("w1a_cout", 64'(cout1), 1);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1b_busy", 64'(busy1), 1);
    chk("w1b_sum_hold", 64'(sum1), 1);
    chk("w1b_cout_hold", 64'(cout1), 1);
    @(negedge clk);
    chk("w1b_done", 64'(done1), 1);
    chk("w1b_sum", 64'(sum1), 1);
    chk("w1b_cout", 64'(cout1), 0);
    @(negedge clk);
    chk("w1b_done_pulse", 64'(done1), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
